// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a flash master (bootloader or bench) and the flash responder.
// The master drives select, clock and data out; the responder returns MISO.
interface spi_flash_responder_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_cs,
    output spi_sck,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_cs,
    input  spi_sck,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in: emulates READ/PP/RDSR/WREN/WRDI/RDID/CE over an on-chip byte
// array, oversampling the SPI pins with the system clock. MEM_ADDR_BITS must be 8..24.
module spi_flash_responder #(
  parameter int          MEM_ADDR_BITS         = 10,
  parameter logic [23:0] JEDEC_ID              = 24'hEF4016,
  parameter int          ERASE_CYCLES_PER_BYTE = 1
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  spi_flash_responder_if.slave  spi,
  output logic                  busy,
  output logic                  cmd_done
);

  localparam int AW  = MEM_ADDR_BITS;
  localparam int ECW = (ERASE_CYCLES_PER_BYTE > 1) ? $clog2(ERASE_CYCLES_PER_BYTE) : 1;
  localparam logic [ECW-1:0] ERASE_LAST = ECW'(ERASE_CYCLES_PER_BYTE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_STATUS,
    S_JEDEC,
    S_IGNORE
  } state_t;

  logic [7:0] mem [1 << AW];

  logic cs_s1_q, cs_s2_q;
  logic sck_s1_q, sck_s2_q, sck_hist_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [6:0]      rx_q, rx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      tx_q, tx_d;
  logic            miso_q, miso_d;
  logic            is_prog_q, is_prog_d;
  logic [1:0]      jedec_idx_q, jedec_idx_d;
  logic [7:0]      op_q, op_d;
  logic            done_pend_q, done_pend_d;
  logic            cmd_done_q, cmd_done_d;
  logic            wel_q, wel_d;
  logic            wip_q, wip_d;
  logic [AW-1:0]   erase_addr_q, erase_addr_d;
  logic [ECW-1:0]  erase_cyc_q, erase_cyc_d;
  logic [1:0]      rmw_q, rmw_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_byte_q, wr_byte_d;

  logic [7:0]      mem_rd_q;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic [AW-1:0]   mem_raddr;

  logic            sck_rise, sck_fall;
  logic [7:0]      rx_byte;
  logic [7:0]      out_byte;
  logic [AW-1:0]   page_next;

  assign sck_rise  = sck_s2_q & ~sck_hist_q;
  assign sck_fall  = ~sck_s2_q & sck_hist_q;
  assign rx_byte   = {rx_q, mosi_s2_q};
  assign mem_raddr = (rmw_q == 2'd1) ? wr_addr_q : addr_q;

  always_comb begin
    page_next      = addr_q;
    page_next[7:0] = addr_q[7:0] + 8'd1;
  end

  // Byte presented at the start of each outgoing byte, chosen by the active response state.
  always_comb begin
    out_byte = 8'hFF;
    case (state_q)
      S_RD_DATA: out_byte = mem_rd_q;
      S_STATUS:  out_byte = {6'b0, wel_q, wip_q};
      S_JEDEC: begin
        case (jedec_idx_q)
          2'd0:    out_byte = JEDEC_ID[23:16];
          2'd1:    out_byte = JEDEC_ID[15:8];
          2'd2:    out_byte = JEDEC_ID[7:0];
          default: out_byte = 8'hFF;
        endcase
      end
      default: out_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    addr_d       = addr_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    is_prog_d    = is_prog_q;
    jedec_idx_d  = jedec_idx_q;
    op_d         = op_q;
    done_pend_d  = done_pend_q;
    cmd_done_d   = 1'b0;
    wel_d        = wel_q;
    wip_d        = wip_q;
    erase_addr_d = erase_addr_q;
    erase_cyc_d  = erase_cyc_q;
    rmw_d        = rmw_q;
    wr_addr_d    = wr_addr_q;
    wr_byte_d    = wr_byte_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_q;
    mem_wdata    = mem_rd_q & wr_byte_q;

    // Page-program commit: one clock to fetch the old byte, one to write the AND result.
    case (rmw_q)
      2'd1: rmw_d = 2'd2;
      2'd2: begin
        mem_we = 1'b1;
        rmw_d  = 2'd0;
      end
      default: rmw_d = 2'd0;
    endcase

    if (wip_q) begin
      if (erase_cyc_q == ERASE_LAST) begin
        erase_cyc_d  = '0;
        mem_we       = 1'b1;
        mem_waddr    = erase_addr_q;
        mem_wdata    = 8'hFF;
        erase_addr_d = erase_addr_q + 1'b1;
        if (erase_addr_q == '1) begin
          wip_d = 1'b0;
          wel_d = 1'b0;
        end
      end else begin
        erase_cyc_d = erase_cyc_q + 1'b1;
      end
    end

    if (cs_s2_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b1;
      if (done_pend_q) begin
        done_pend_d = 1'b0;
        cmd_done_d  = 1'b1;
        case (op_q)
          8'h06: wel_d = 1'b1;
          8'h04: wel_d = 1'b0;
          8'h02: wel_d = 1'b0;
          8'hC7: begin
            wip_d        = 1'b1;
            erase_addr_d = '0;
            erase_cyc_d  = '0;
          end
          default: ;
        endcase
      end
    end else if (sck_rise) begin
      cnt_d = cnt_q + 5'd1;
      rx_d  = rx_byte[6:0];
      case (state_q)
        S_IDLE, S_CMD: begin
          state_d = S_CMD;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            op_d    = rx_byte;
            state_d = S_IGNORE;
            if (!wip_q || rx_byte == 8'h05) begin
              case (rx_byte)
                8'h03: begin
                  state_d     = S_ADDR;
                  is_prog_d   = 1'b0;
                  done_pend_d = 1'b1;
                end
                8'h02: begin
                  if (wel_q) begin
                    state_d     = S_ADDR;
                    is_prog_d   = 1'b1;
                    done_pend_d = 1'b1;
                  end
                end
                8'h05: begin
                  state_d     = S_STATUS;
                  done_pend_d = 1'b1;
                end
                8'h06, 8'h04: done_pend_d = 1'b1;
                8'h9F: begin
                  state_d     = S_JEDEC;
                  jedec_idx_d = 2'd0;
                  done_pend_d = 1'b1;
                end
                8'hC7: done_pend_d = wel_q;
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          // Only the low address bits survive the shift, which gives the aliasing for free.
          addr_d = {addr_q[AW-2:0], mosi_s2_q};
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            state_d = is_prog_q ? S_WR_DATA : S_RD_DATA;
          end
        end
        S_WR_DATA: begin
          if (cnt_q[2:0] == 3'd7) begin
            wr_byte_d = rx_byte;
            wr_addr_d = addr_q;
            rmw_d     = 2'd1;
            addr_d    = page_next;
          end
        end
        default: ;
      endcase
    end else if (sck_fall) begin
      case (state_q)
        S_RD_DATA, S_STATUS, S_JEDEC: begin
          if (cnt_q[2:0] == 3'd0) begin
            miso_d = out_byte[7];
            tx_d   = {out_byte[6:0], 1'b1};
            if (state_q == S_RD_DATA) addr_d = addr_q + 1'b1;
            if (state_q == S_JEDEC && jedec_idx_q != 2'd3) jedec_idx_d = jedec_idx_q + 2'd1;
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b1};
          end
        end
        default: miso_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1_q      <= 1'b1;
      cs_s2_q      <= 1'b1;
      sck_s1_q     <= 1'b0;
      sck_s2_q     <= 1'b0;
      sck_hist_q   <= 1'b0;
      mosi_s1_q    <= 1'b0;
      mosi_s2_q    <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rx_q         <= '0;
      addr_q       <= '0;
      tx_q         <= 8'hFF;
      miso_q       <= 1'b1;
      is_prog_q    <= 1'b0;
      jedec_idx_q  <= 2'd0;
      op_q         <= 8'h00;
      done_pend_q  <= 1'b0;
      cmd_done_q   <= 1'b0;
      wel_q        <= 1'b0;
      wip_q        <= 1'b0;
      erase_addr_q <= '0;
      erase_cyc_q  <= '0;
      rmw_q        <= 2'd0;
      wr_addr_q    <= '0;
      wr_byte_q    <= 8'h00;
    end else begin
      cs_s1_q      <= spi.spi_cs;
      cs_s2_q      <= cs_s1_q;
      sck_s1_q     <= spi.spi_sck;
      sck_s2_q     <= sck_s1_q;
      sck_hist_q   <= sck_s2_q;
      mosi_s1_q    <= spi.spi_mosi;
      mosi_s2_q    <= mosi_s1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      is_prog_q    <= is_prog_d;
      jedec_idx_q  <= jedec_idx_d;
      op_q         <= op_d;
      done_pend_q  <= done_pend_d;
      cmd_done_q   <= cmd_done_d;
      wel_q        <= wel_d;
      wip_q        <= wip_d;
      erase_addr_q <= erase_addr_d;
      erase_cyc_q  <= erase_cyc_d;
      rmw_q        <= rmw_d;
      wr_addr_q    <= wr_addr_d;
      wr_byte_q    <= wr_byte_d;
    end
  end

  // Storage is deliberately left unreset; contents are defined only after a chip erase.
  always_ff @(posedge clk_48mhz) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rd_q <= mem[mem_raddr];
  end

  assign spi.spi_miso = miso_q;
  assign busy         = wip_q;
  assign cmd_done     = cmd_done_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised bench for spi_flash_responder: a flash model predicts every MISO byte and cmd_done
// pulse into scoreboard queues that independent monitors drain.
module tb_spi_flash_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = 4;
  localparam int GAP   = 8;

  logic clk_48mhz = 1'b0;
  logic reset_n;
  logic busy;
  logic cmd_done;

  spi_flash_responder_if sif ();

  spi_flash_responder #(
    .MEM_ADDR_BITS         (AW),
    .JEDEC_ID              (24'hEF4016),
    .ERASE_CYCLES_PER_BYTE (1)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .spi       (sif),
    .busy      (busy),
    .cmd_done  (cmd_done)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  bit         done_sb[$];
  logic [7:0] tx_list[$];
  logic [7:0] exp_list[$];
  logic [7:0] data_list[$];

  logic [7:0] mem_m [DEPTH];
  logic [7:0] jedec_b [3] = '{8'hEF, 8'h40, 8'h16};
  bit         m_wel;
  bit         m_wip;

  bit         mon_en   = 1'b0;
  int         busy_cnt = 0;
  int         busy_len = 0;
  logic [7:0] mon_sh;
  int         mon_n;
  int         pulses;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MISO monitor: assembles bytes as a mode-0 master would and checks them against the scoreboard.
  initial begin
    wait (mon_en);
    mon_n = 0;
    forever begin
      @(posedge sif.spi_sck or posedge sif.spi_cs);
      if (sif.spi_cs) begin
        mon_n = 0;
      end else begin
        mon_sh = {mon_sh[6:0], sif.spi_miso};
        mon_n++;
        if (mon_n == 8) begin
          mon_n = 0;
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL miso_unexpected: got %0h expected none", mon_sh);
          end else begin
            check_output("miso_byte", mon_sh, sb_q.pop_front());
          end
        end
      end
    end
  end

  // cmd_done monitor: counts pulses in a window after each chip-select release.
  initial begin
    bit e;
    wait (mon_en);
    forever begin
      @(posedge sif.spi_cs);
      pulses = 0;
      repeat (12) begin
        @(negedge clk_48mhz);
        if (cmd_done === 1'b1) pulses++;
      end
      if (done_sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL cmd_done_unexpected: got %0d pulses expected none", pulses);
      end else begin
        e = done_sb.pop_front();
        check_output("cmd_done_pulses", pulses, e ? 1 : 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (busy === 1'b1) busy_cnt++;
      else if (busy_cnt != 0) begin
        busy_len = busy_cnt;
        busy_cnt = 0;
      end
    end
  end

  task automatic spi_bit(input logic b);
    sif.spi_mosi = b;
    repeat (HALF) @(negedge clk_48mhz);
    sif.spi_sck = 1'b1;
    repeat (HALF) @(negedge clk_48mhz);
    sif.spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) spi_bit(v[b]);
  endtask

  task automatic send_txn(input bit exp_done, input int part_bits, input logic [7:0] part_val);
    logic [7:0] t;
    foreach (exp_list[i]) sb_q.push_back(exp_list[i]);
    done_sb.push_back(exp_done);
    @(negedge clk_48mhz);
    sif.spi_cs = 1'b0;
    foreach (tx_list[i]) begin
      t = tx_list[i];
      spi_byte(t);
    end
    for (int b = 0; b < part_bits; b++) spi_bit(part_val[7-b]);
    repeat (HALF) @(negedge clk_48mhz);
    sif.spi_cs = 1'b1;
    repeat (GAP) @(negedge clk_48mhz);
    tx_list.delete();
    exp_list.delete();
  endtask

  task automatic push_addr(input logic [23:0] a);
    tx_list.push_back(a[23:16]);
    tx_list.push_back(a[15:8]);
    tx_list.push_back(a[7:0]);
    repeat (3) exp_list.push_back(8'hFF);
  endtask

  // Flash model: predicts the response of one command from the current model state, then issues it.
  task automatic apply_stimulus(input logic [7:0] op, input logic [23:0] addr, input int len, input int part);
    bit honoured;
    int base;
    int p;
    base = int'(addr) % DEPTH;
    honoured = 1'b0;
    tx_list.push_back(op);
    exp_list.push_back(8'hFF);
    case (op)
      8'h03: begin
        honoured = !m_wip;
        push_addr(addr);
        for (int i = 0; i < len; i++) begin
          tx_list.push_back(8'($urandom));
          exp_list.push_back(honoured ? mem_m[(base + i) % DEPTH] : 8'hFF);
        end
      end
      8'h02: begin
        honoured = !m_wip && m_wel;
        push_addr(addr);
        foreach (data_list[i]) begin
          tx_list.push_back(data_list[i]);
          exp_list.push_back(8'hFF);
          if (honoured) begin
            p = (base / 256) * 256 + ((base + i) % 256);
            mem_m[p] = mem_m[p] & data_list[i];
          end
        end
        if (honoured) m_wel = 1'b0;
      end
      8'h05: begin
        honoured = 1'b1;
        for (int i = 0; i < len; i++) begin
          tx_list.push_back(8'h00);
          exp_list.push_back({6'b0, m_wel, m_wip});
        end
      end
      8'h06: begin
        honoured = !m_wip;
        if (honoured) m_wel = 1'b1;
      end
      8'h04: begin
        honoured = !m_wip;
        if (honoured) m_wel = 1'b0;
      end
      8'h9F: begin
        honoured = !m_wip;
        for (int i = 0; i < len; i++) begin
          tx_list.push_back(8'($urandom));
          exp_list.push_back((honoured && i < 3) ? jedec_b[i] : 8'hFF);
        end
      end
      8'hC7: begin
        honoured = !m_wip && m_wel;
        if (honoured) m_wip = 1'b1;
      end
      default: begin
        for (int i = 0; i < len; i++) begin
          tx_list.push_back(8'($urandom));
          exp_list.push_back(8'hFF);
        end
      end
    endcase
    data_list.delete();
    send_txn(honoured, part, 8'($urandom));
  endtask

  task automatic wait_erase();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk_48mhz);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL erase_timeout: got busy=%b after %0d clocks expected 0", busy, n);
    end
    repeat (2) @(negedge clk_48mhz);
    check_output("erase_busy_clocks", busy_len, DEPTH);
    m_wip = 1'b0;
    m_wel = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
  endtask

  initial begin
    int r;
    int n;
    logic [7:0] op;
    sif.spi_cs   = 1'b1;
    sif.spi_sck  = 1'b0;
    sif.spi_mosi = 1'b0;
    reset_n      = 1'b0;
    m_wel        = 1'b0;
    m_wip        = 1'b0;
    repeat (3) @(negedge clk_48mhz);
    check_output("reset_miso", sif.spi_miso, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_cmd_done", cmd_done, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_48mhz);
    mon_en = 1'b1;
    repeat (2) @(negedge clk_48mhz);

    apply_stimulus(8'h9F, 24'h0, 4, 0);
    apply_stimulus(8'h05, 24'h0, 1, 0);

    apply_stimulus(8'h06, 24'h0, 0, 0);
    apply_stimulus(8'hC7, 24'h0, 0, 0);
    check_output("busy_during_erase", busy, 1);
    apply_stimulus(8'h05, 24'h0, 2, 0);
    apply_stimulus(8'h03, 24'h000010, 2, 0);
    wait_erase();
    apply_stimulus(8'h05, 24'h0, 1, 0);

    apply_stimulus(8'h06, 24'h0, 0, 0);
    data_list = '{8'hA5, 8'h3C};
    apply_stimulus(8'h02, 24'h000010, 0, 0);
    apply_stimulus(8'h03, 24'h000010, 2, 0);

    data_list = '{8'h00};
    apply_stimulus(8'h02, 24'h000020, 0, 0);
    apply_stimulus(8'h03, 24'h000020, 1, 0);
    apply_stimulus(8'h05, 24'h0, 1, 0);

    apply_stimulus(8'h06, 24'h0, 0, 0);
    data_list = '{8'h11, 8'h22, 8'h33};
    apply_stimulus(8'h02, 24'h0000FE, 0, 0);
    apply_stimulus(8'h03, 24'h0000FE, 2, 0);
    apply_stimulus(8'h03, 24'h0003FF, 2, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: apply_stimulus(8'h06, 24'h0, 0, 0);
        2:    apply_stimulus(8'h04, 24'h0, 0, 0);
        3, 4: begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) data_list.push_back(8'($urandom));
          apply_stimulus(8'h02, 24'($urandom), 0, $urandom_range(0, 3));
        end
        5, 6: apply_stimulus(8'h03, 24'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));
        7:    apply_stimulus(8'h05, 24'h0, $urandom_range(1, 2), 0);
        8:    apply_stimulus(8'h9F, 24'h0, $urandom_range(1, 4), 0);
        default: begin
          op = 8'($urandom);
          if (op == 8'h03 || op == 8'h02 || op == 8'h05 || op == 8'h06 ||
              op == 8'h04 || op == 8'h9F || op == 8'hC7) op = 8'hAB;
          apply_stimulus(op, 24'h0, $urandom_range(0, 2), 0);
        end
      endcase
    end

    // Reset in the middle of a READ address phase with WEL set.
    apply_stimulus(8'h06, 24'h0, 0, 0);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'hFF);
    done_sb.push_back(1'b0);
    @(negedge clk_48mhz);
    sif.spi_cs = 1'b0;
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_bit(1'b0);
    spi_bit(1'b1);
    spi_bit(1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_48mhz);
    check_output("midread_reset_miso", sif.spi_miso, 1);
    check_output("midread_reset_busy", busy, 0);
    sif.spi_cs = 1'b1;
    repeat (GAP + 12) @(negedge clk_48mhz);
    reset_n = 1'b1;
    m_wel = 1'b0;
    repeat (4) @(negedge clk_48mhz);
    apply_stimulus(8'h05, 24'h0, 1, 0);
    apply_stimulus(8'h9F, 24'h0, 3, 0);

    n = 0;
    while ((sb_q.size() != 0 || done_sb.size() != 0) && n < 200) begin
      @(negedge clk_48mhz);
      n++;
    end
    if (sb_q.size() != 0 || done_sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes %0d done entries left expected 0",
               sb_q.size(), done_sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
